debounce_one_shot: RTL

DEBOUNCE_ONE_SHOT -- requirements
Module: debounce_one_shot

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/debounce_one_shot.sv | 116 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce / one-shot block.
//   db_state_t        : debounce FSM state encoding
//   DB_COUNT_DEFAULT  : stable-sample count for 10 ms at 50 MHz
//   PRESS_CNT_ADDR    : IOBUS address decoded by the wrapper for PRESS_CNT
//                       reads and CLR writes
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int          DB_COUNT_DEFAULT = 500000;
    localparam logic [31:0] PRESS_CNT_ADDR   = 32'h1100_0020;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs (buttons, switch bus).
//   CLK : system clock
//   RST : synchronous reset, active-high, clears both stages
//   D   : asynchronous input, WIDTH bits
//   Q   : synchronized output, two CLK edges behind D
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= '0;
            Q    <= '0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_one_shot.sv
// Button debouncer with a one-cycle press pulse and an 8-bit press counter.
//   CLK       : system clock
//   RST       : synchronous reset, active-high
//   BTN_IN    : raw, bouncing, asynchronous button level
//   CLR       : synchronous clear of PRESS_CNT (IOBUS write decode)
//   BTN_DB    : debounced level (registered)
//   BTN_PULSE : one-cycle pulse on each accepted press (registered)
//   PRESS_CNT : accepted-press count, wraps 255 -> 0
module debounce_one_shot
    import debounce_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_IN,
    input  logic       CLR,
    output logic       BTN_DB,
    output logic       BTN_PULSE,
    output logic [7:0] PRESS_CNT
);

    localparam int            CW       = $clog2(DB_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic          btn_s;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          db_nxt, pulse_nxt;

    sync_2ff #(.WIDTH(1)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (BTN_IN),
        .Q   (btn_s)
    );

    // State register. Outputs are registered from the next-state decode so
    // they line up with the state itself rather than lagging it by a cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            BTN_DB    <= 1'b0;
            BTN_PULSE <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            BTN_DB    <= db_nxt;
            BTN_PULSE <= pulse_nxt;
        end
    end

    // Next-state and stability counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to PRESSED without a new pulse.
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode; only the qualified press transition fires the pulse.
    always_comb begin
        db_nxt    = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
        pulse_nxt = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    end

    // Press counter; CLR beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            PRESS_CNT <= 8'd0;
        end else if (BTN_PULSE) begin
            PRESS_CNT <= PRESS_CNT + 8'd1;
        end
    end

endmodule
